ringnode_fifo: RTL and testbench

- Parametrised successor ring node: one stop on the unidirectional slotted packet ring, with buffered client interface.
- Decouples client from ring timing via TX FIFO (depth TXDEPTH) and RX FIFO (depth RXDEPTH), using valid/ready handshakes.
- Ring-side back-pressure: a packet addressed here while RX is full is deflected round the ring and retried on its next lap, never dropped.
- Drop-in for the SPI-attached node family; the client side attaches to SPI, UART or on-chip logic.

---
 rtl/ring_pkg.sv | 43 ++++
 rtl/ringfifo.sv | 54 +++++
 rtl/ringnode_fifo.sv | 127 ++++++++++++
 tb/tb_ringnode_fifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared slot-format helpers for the slotted packet ring node and its FIFOs.
// Slot layout: {occupied, dest[ABITS], payload[PBITS]}; helpers work on a 64-bit carrier.
package ring_pkg;

    localparam int STAT_W   = 16;
    localparam int SLOT_MAX = 64;

    typedef logic [SLOT_MAX-1:0] slot_wide_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic slot_wide_t field_mask(input int n);
        return (slot_wide_t'(1) << n) - slot_wide_t'(1);
    endfunction

    function automatic logic slot_occ(input slot_wide_t s, input int width);
        return s[width-1];
    endfunction

    function automatic slot_wide_t slot_dest(input slot_wide_t s, input int width, input int abits);
        return (s >> (width - 1 - abits)) & field_mask(abits);
    endfunction

    function automatic slot_wide_t slot_payload(input slot_wide_t s, input int width, input int abits);
        return s & field_mask(width - 1 - abits);
    endfunction

    // The returned slot always has the occupied bit set.
    function automatic slot_wide_t slot_build(input slot_wide_t dest, input slot_wide_t payload,
                                              input int width, input int abits);
        return (slot_wide_t'(1) << (width - 1))
             | ((dest & field_mask(abits)) << (width - 1 - abits))
             | (payload & field_mask(width - 1 - abits));
    endfunction

endpackage

// File: rtl/ringfifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; rdata reads zero while empty.
// Pushes while full and pops while empty are ignored.
module ringfifo
    import ring_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ringnode_fifo.sv
// One stop on a unidirectional slotted ring with TX/RX FIFOs between client and ring.
// Optional RINGNODE_STATS_EN adds saturating stat_deflect / stat_rx event counters.
module ringnode_fifo
    import ring_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ABITS   = 3,
    parameter int ADDRESS = 0,
    parameter int TXDEPTH = 4,
    parameter int RXDEPTH = 4,
    parameter int PBITS   = WIDTH - 1 - ABITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  fromring,
    output logic [WIDTH-1:0]  toring,
    input  logic [ABITS-1:0]  tx_dest,
    input  logic [PBITS-1:0]  tx_payload,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [PBITS-1:0]  rx_payload,
    output logic              rx_valid,
    input  logic              rx_ready
`ifdef RINGNODE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_deflect,
    output logic [STAT_W-1:0] stat_rx
`endif
);

    localparam int TXW = ABITS + PBITS;

    slot_wide_t       in_wide, dest_wide, pay_wide, out_wide;
    logic             in_occ;
    logic [ABITS-1:0] in_dest;
    logic [PBITS-1:0] in_payload;
    logic             for_me, rx_push, deflect, tx_pop, rx_pop;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [TXW-1:0]   tx_head;
    logic [WIDTH-1:0] toring_q, toring_d;

    ringfifo #(.DW(TXW), .DEPTH(TXDEPTH)) u_txfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (tx_pop),
        .wdata ({tx_dest, tx_payload}),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    ringfifo #(.DW(PBITS), .DEPTH(RXDEPTH)) u_rxfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (in_payload),
        .rdata (rx_payload),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign toring   = toring_q;

    // rx_full is the registered flag, so a same-cycle client pop never makes room.
    always_comb begin
        in_wide    = slot_wide_t'(fromring);
        in_occ     = slot_occ(in_wide, WIDTH);
        dest_wide  = slot_dest(in_wide, WIDTH, ABITS);
        pay_wide   = slot_payload(in_wide, WIDTH, ABITS);
        in_dest    = dest_wide[ABITS-1:0];
        in_payload = pay_wide[PBITS-1:0];
        out_wide   = slot_build(slot_wide_t'(tx_head[TXW-1 -: ABITS]),
                                slot_wide_t'(tx_head[PBITS-1:0]), WIDTH, ABITS);

        for_me  = in_occ && (in_dest == ABITS'(ADDRESS));
        rx_push = for_me && !rx_full;
        deflect = for_me && rx_full;
        tx_pop  = (!in_occ || rx_push) && !tx_empty;

        toring_d = '0;
        if (in_occ && !rx_push) toring_d = fromring;
        else if (tx_pop)        toring_d = out_wide[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) toring_q <= '0;
        else     toring_q <= toring_d;
    end

    logic unused_bits;
    assign unused_bits = ^{dest_wide[SLOT_MAX-1:ABITS], pay_wide[SLOT_MAX-1:PBITS],
                           out_wide[SLOT_MAX-1:WIDTH]};

`ifdef RINGNODE_STATS_EN
    logic [STAT_W-1:0] stat_deflect_q, stat_deflect_d;
    logic [STAT_W-1:0] stat_rx_q, stat_rx_d;

    always_comb begin
        stat_deflect_d = stat_deflect_q;
        stat_rx_d      = stat_rx_q;
        if (deflect && (stat_deflect_q != '1)) stat_deflect_d = stat_deflect_q + STAT_W'(1);
        if (rx_push && (stat_rx_q != '1))      stat_rx_d      = stat_rx_q + STAT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_deflect_q <= '0;
            stat_rx_q      <= '0;
        end else begin
            stat_deflect_q <= stat_deflect_d;
            stat_rx_q      <= stat_rx_d;
        end
    end

    assign stat_deflect = stat_deflect_q;
    assign stat_rx      = stat_rx_q;
`else
    logic unused_deflect;
    assign unused_deflect = deflect;
`endif

endmodule

// File: tb/tb_ringnode_fifo.sv
// Directed self-checking bench for ringnode_fifo at ADDRESS=2, 16-bit slots, depth-4 FIFOs.
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
module tb_ringnode_fifo;

    localparam int WIDTH   = 16;
    localparam int ABITS   = 3;
    localparam int ADDRESS = 2;
    localparam int TXDEPTH = 4;
    localparam int RXDEPTH = 4;
    localparam int PBITS   = WIDTH - 1 - ABITS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] fromring;
    logic [WIDTH-1:0] toring;
    logic [ABITS-1:0] tx_dest;
    logic [PBITS-1:0] tx_payload;
    logic             tx_valid;
    logic             tx_ready;
    logic [PBITS-1:0] rx_payload;
    logic             rx_valid;
    logic             rx_ready;
`ifdef RINGNODE_STATS_EN
    logic [15:0]      stat_deflect;
    logic [15:0]      stat_rx;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ringnode_fifo #(
        .WIDTH(WIDTH), .ABITS(ABITS), .ADDRESS(ADDRESS), .TXDEPTH(TXDEPTH), .RXDEPTH(RXDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fromring   (fromring),
        .toring     (toring),
        .tx_dest    (tx_dest),
        .tx_payload (tx_payload),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_payload (rx_payload),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
`ifdef RINGNODE_STATS_EN
        ,
        .stat_deflect (stat_deflect),
        .stat_rx      (stat_rx)
`endif
    );

    function automatic logic [WIDTH-1:0] mk(input logic [ABITS-1:0] d, input logic [PBITS-1:0] p);
        return {1'b1, d, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fromring   = '0;
        tx_dest    = '0;
        tx_payload = '0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        tests_run++;
        if (toring !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_toring: got %h expected 0000", toring);
        end
        tests_run++;
        if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_payload !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got tx_ready=%b rx_valid=%b rx_payload=%h expected 1 0 000",
                     tx_ready, rx_valid, rx_payload);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_receive();
        fromring = mk(3'd2, 12'hABC);
        step();
        fromring = '0;
        tests_run++;
        if (rx_valid !== 1'b1 || rx_payload !== 12'hABC || toring !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL receive: got rx_valid=%b rx_payload=%h toring=%h expected 1 abc 0000",
                     rx_valid, rx_payload, toring);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0 || rx_payload !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL receive_pop: got rx_valid=%b rx_payload=%h expected 0 000",
                     rx_valid, rx_payload);
        end
    endtask

    task automatic test_pass_through();
        fromring = mk(3'd5, 12'h123);
        step();
        fromring = '0;
        tests_run++;
        if (toring !== 16'hD123 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pass_through: got toring=%h rx_valid=%b expected d123 0", toring, rx_valid);
        end
        step();
        tests_run++;
        if (toring !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL pass_through_after: got %h expected 0000", toring);
        end
    endtask

    task automatic test_insert();
        logic [PBITS-1:0] p;
        tx_dest    = 3'd4;
        tx_payload = 12'h055;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        tests_run++;
        if (toring !== 16'h0000 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL insert_latency1: got toring=%h tx_ready=%b expected 0000 1", toring, tx_ready);
        end
        step();
        tests_run++;
        if (toring !== 16'hC055) begin
            tests_failed++;
            $display("[TB] FAIL insert_idle: got %h expected c055", toring);
        end
        // Foreign traffic on every slot must hold the queued packet back.
        fromring   = mk(3'd5, 12'h111);
        tx_dest    = 3'd6;
        tx_payload = 12'h077;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        tests_run++;
        if (toring !== 16'hD111) begin
            tests_failed++;
            $display("[TB] FAIL insert_busy0: got %h expected d111", toring);
        end
        for (int i = 0; i < 4; i++) begin
            p = 12'h120 + i[11:0];
            fromring = mk(3'd5, p);
            step();
            tests_run++;
            if (toring !== {4'hD, p}) begin
                tests_failed++;
                $display("[TB] FAIL insert_busy%0d: got %h expected %h", i + 1, toring, {4'hD, p});
            end
        end
        fromring = '0;
        step();
        tests_run++;
        if (toring !== 16'hE077) begin
            tests_failed++;
            $display("[TB] FAIL insert_free_slot: got %h expected e077", toring);
        end
        tx_dest    = 3'd2;
        tx_payload = 12'h0AA;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        tests_run++;
        if (toring !== 16'hA0AA) begin
            tests_failed++;
            $display("[TB] FAIL insert_self: got %h expected a0aa", toring);
        end
        fromring = 16'hA0AA;
        step();
        fromring = '0;
        tests_run++;
        if (rx_valid !== 1'b1 || rx_payload !== 12'h0AA || toring !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL self_lap: got rx_valid=%b rx_payload=%h toring=%h expected 1 0aa 0000",
                     rx_valid, rx_payload, toring);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic test_deflect();
        logic [PBITS-1:0] p;
        pulse_reset();
        for (int i = 0; i < RXDEPTH; i++) begin
            p = 12'h101 + i[11:0];
            fromring = mk(3'd2, p);
            step();
            tests_run++;
            if (toring !== 16'h0000) begin
                tests_failed++;
                $display("[TB] FAIL deflect_absorb%0d: got %h expected 0000", i, toring);
            end
        end
        fromring = mk(3'd2, 12'h105);
        step();
        fromring = '0;
        tests_run++;
        if (toring !== 16'hA105 || rx_valid !== 1'b1 || rx_payload !== 12'h101) begin
            tests_failed++;
            $display("[TB] FAIL deflect_full: got toring=%h rx_valid=%b rx_payload=%h expected a105 1 101",
                     toring, rx_valid, rx_payload);
        end
`ifdef RINGNODE_STATS_EN
        tests_run++;
        if (stat_deflect !== 16'd1 || stat_rx !== 16'd4) begin
            tests_failed++;
            $display("[TB] FAIL stats_first: got deflect=%0d rx=%0d expected 1 4", stat_deflect, stat_rx);
        end
`endif
        // A pop in the same cycle does not free room for the arriving packet.
        rx_ready = 1'b1;
        fromring = mk(3'd2, 12'h105);
        step();
        rx_ready = 1'b0;
        fromring = '0;
        tests_run++;
        if (toring !== 16'hA105 || rx_payload !== 12'h102) begin
            tests_failed++;
            $display("[TB] FAIL deflect_conservative: got toring=%h rx_payload=%h expected a105 102",
                     toring, rx_payload);
        end
        fromring = mk(3'd2, 12'h105);
        step();
        fromring = '0;
        tests_run++;
        if (toring !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL deflect_retry: got %h expected 0000", toring);
        end
`ifdef RINGNODE_STATS_EN
        tests_run++;
        if (stat_deflect !== 16'd2 || stat_rx !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL stats_second: got deflect=%0d rx=%0d expected 2 5", stat_deflect, stat_rx);
        end
`endif
        for (int i = 0; i < RXDEPTH; i++) begin
            p = 12'h102 + i[11:0];
            tests_run++;
            if (rx_valid !== 1'b1 || rx_payload !== p) begin
                tests_failed++;
                $display("[TB] FAIL rx_order%0d: got rx_valid=%b rx_payload=%h expected 1 %h",
                         i, rx_valid, rx_payload, p);
            end
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
        end
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rx_drained: got rx_valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_tx_full();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp_slot;
        logic             busy;
        logic             push_ok;
        int               pushed;
        int               cyc;
        pulse_reset();
        rx_ready = 1'b1;
        pushed   = 0;
        cyc      = 0;
        // First TXDEPTH cycles busy to fill the FIFO, then a free slot every other cycle.
        while ((pushed < 12 || q.size() > 0) && cyc < 80) begin
            busy       = (cyc < TXDEPTH) || (cyc % 2 == 1);
            fromring   = busy ? mk(3'd5, 12'h200 + cyc[11:0]) : '0;
            tx_valid   = (pushed < 12);
            tx_dest    = 3'((pushed + 3) % 8);
            tx_payload = 12'h300 + pushed[11:0];
            push_ok    = tx_valid && (q.size() < TXDEPTH);
            if (busy)              exp_slot = fromring;
            else if (q.size() > 0) exp_slot = q.pop_front();
            else                   exp_slot = '0;
            if (push_ok) begin
                q.push_back(mk(tx_dest, tx_payload));
                pushed++;
            end
            step();
            tests_run++;
            if (toring !== exp_slot || tx_ready !== (q.size() < TXDEPTH)) begin
                tests_failed++;
                $display("[TB] FAIL tx_cycle%0d: got toring=%h tx_ready=%b expected %h %b",
                         cyc, toring, tx_ready, exp_slot, (q.size() < TXDEPTH));
            end
            cyc++;
        end
        tx_valid = 1'b0;
        fromring = '0;
        tests_run++;
        if (cyc >= 80) begin
            tests_failed++;
            $display("[TB] FAIL tx_timeout: got %0d pushed, %0d queued expected 12 0", pushed, q.size());
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        fromring = mk(3'd2, 12'h0EE);
        step();
        fromring   = mk(3'd5, 12'h155);
        tx_dest    = 3'd1;
        tx_payload = 12'h0DD;
        tx_valid   = 1'b1;
        step();
        step();
        tx_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (toring !== 16'h0000 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_payload !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got toring=%h tx_ready=%b rx_valid=%b rx_payload=%h expected 0000 1 0 000",
                     toring, tx_ready, rx_valid, rx_payload);
        end
        fromring = '0;
        rst      = 1'b0;
        step();
        tests_run++;
        if (toring !== 16'h0000 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_discard: got toring=%h rx_valid=%b expected 0000 0", toring, rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_pass_through();
        test_insert();
        test_deflect();
        test_tx_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
